// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor: one carry-chain chunk per stage, valid/ready with full backpressure.
// Optional signed saturation of the result when ADD_SUB_PIPE_SAT_EN is defined.
module add_sub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             negative_flag
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Inter-stage registers; entry k holds the state leaving stage k (last entry unused,
  // the final stage writes the output registers instead).
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             c_q   [STAGES];
  logic             z_q   [STAGES];
  logic             v_q   [STAGES];

  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic             src_c   [STAGES];
  logic             src_z   [STAGES];
  logic             src_v   [STAGES];
  logic [CHUNK:0]   part    [STAGES];
  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic             nxt_c   [STAGES];
  logic             nxt_z   [STAGES];

  logic             stall;
  logic             ovf;
  logic [WIDTH-1:0] fin_s;
  logic             fin_z;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Subtraction folds into the operand: b is inverted once here, carry-in is mode.
        src_a[k]   = a;
        src_b[k]   = b ^ {WIDTH{mode}};
        src_c[k]   = mode;
        src_sum[k] = '0;
        src_z[k]   = 1'b1;
        src_v[k]   = in_valid;
      end else begin
        src_a[k]   = a_q[(k > 0) ? k - 1 : 0];
        src_b[k]   = b_q[(k > 0) ? k - 1 : 0];
        src_c[k]   = c_q[(k > 0) ? k - 1 : 0];
        src_sum[k] = sum_q[(k > 0) ? k - 1 : 0];
        src_z[k]   = z_q[(k > 0) ? k - 1 : 0];
        src_v[k]   = v_q[(k > 0) ? k - 1 : 0];
      end
      part[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]} + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, src_c[k]};
      nxt_sum[k] = src_sum[k];
      nxt_sum[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      nxt_c[k] = part[k][CHUNK];
      nxt_z[k] = src_z[k] & (part[k][CHUNK-1:0] == '0);
    end
  end

  // Equal operand signs with a differing result sign is the same as carry-in XOR carry-out at the MSB.
  assign ovf = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &
               (nxt_sum[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);

`ifdef ADD_SUB_PIPE_SAT_EN
  always_comb begin
    fin_s = nxt_sum[LAST];
    fin_z = nxt_z[LAST] & ~ovf;
    if (ovf) begin
      fin_s = src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign fin_s = nxt_sum[LAST];
  assign fin_z = nxt_z[LAST];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        z_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      out_valid     <= 1'b0;
      s             <= '0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < LAST; k++) begin
        a_q[k]   <= src_a[k];
        b_q[k]   <= src_b[k];
        sum_q[k] <= nxt_sum[k];
        c_q[k]   <= nxt_c[k];
        z_q[k]   <= nxt_z[k];
        v_q[k]   <= src_v[k];
      end
      out_valid     <= src_v[LAST];
      s             <= fin_s;
      carry_flag    <= nxt_c[LAST];
      overflow_flag <= ovf;
      zero_flag     <= fin_z;
      negative_flag <= fin_s[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Randomized and directed bench for add_sub_pipe against a cycle-level arithmetic reference model.
// Honours ADD_SUB_PIPE_SAT_EN the same way the design does.
module tb_add_sub_pipe;

  localparam int W  = 64;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, mode, out_valid, out_ready;
  logic [W-1:0] a, b, s;
  logic         carry_flag, overflow_flag, zero_flag, negative_flag;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] s;
    logic [3:0]   f;   // {C, V, Z, N}
  } ent_t;

  ent_t pipe [ST];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  add_sub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .zero_flag(zero_flag), .negative_flag(negative_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic md);
    ent_t         e;
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c, v;
    wide = {1'b0, x} + {1'b0, y};
    r    = md ? (x - y) : (x + y);
    c    = md ? (x >= y) : wide[W];
    if (md) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else    v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
`ifdef ADD_SUB_PIPE_SAT_EN
    if (v) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    e.vld = 1'b1;
    e.s   = r;
    e.f   = {c, v, (r == '0), r[W-1]};
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] ops [6];
    ops[0] = '0;
    ops[1] = {1'b0, {(W-1){1'b1}}};
    ops[2] = {1'b1, {(W-1){1'b0}}};
    ops[3] = '1;
    ops[4] = 64'd1;
    ops[5] = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return ops[$urandom_range(0, 4)];
    return ops[5];
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model across the edge.
  task automatic cyc(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic md, input logic ordy, input logic rst, output logic acc);
    logic stall_m;
    in_valid = v; a = aa; b = bb; mode = md; out_ready = ordy; rst_n = rst;
    #1;
    stall_m = pipe[ST-1].vld & ~ordy;
    if (chk_en) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, ~stall_m});
      chk("out_valid", {63'd0, out_valid}, {63'd0, pipe[ST-1].vld});
      if (pipe[ST-1].vld) begin
        chk("s", s, pipe[ST-1].s);
        chk("flags_cvzn", {60'd0, carry_flag, overflow_flag, zero_flag, negative_flag},
            {60'd0, pipe[ST-1].f});
      end
    end
    acc = rst & v & ~stall_m;
    if (!rst) begin
      for (int i = 0; i < ST; i++) pipe[i] = '0;
    end else if (!stall_m) begin
      for (int i = ST - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = v ? ref_op(aa, bb, md) : '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic md);
    logic acc;
    cyc(1'b1, x, y, md, 1'b1, 1'b1, acc);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_s"}, s, 64'd0);
    chk({tag, "_flags"}, {60'd0, carry_flag, overflow_flag, zero_flag, negative_flag}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic acc;
    int   got, lat, guard;
    for (int i = 0; i < ST; i++) pipe[i] = '0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    #1 chk_reset_state("reset");
    chk_en = 1'b1;

    // Directed arithmetic cases, back to back, out_ready held high.
    op(64'd2, 64'd3, 1'b0);
    op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    op(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    op(64'd5, 64'd7, 1'b1);
    op(64'd7, 64'd7, 1'b1);
    op(-64'sd3, -64'sd5, 1'b1);
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    idle(ST + 1);

    // Eight back-to-back ops with alternating out_ready; held ops retry until accepted.
    got = 0; guard = 0;
    while (got < 8 && guard < 100) begin
      logic [W-1:0] x, y;
      logic         md;
      x = rnd_op(); y = rnd_op(); md = 1'($urandom_range(0, 1));
      acc = 1'b0;
      while (!acc && guard < 100) begin
        cyc(1'b1, x, y, md, 1'(guard % 2 == 0), 1'b1, acc);
        guard++;
      end
      if (acc) got++;
    end
    chk("stream_accepted", 64'(got), 64'd8);
    for (int i = 0; i < 2 * ST + 2; i++) cyc(1'b0, '0, '0, 1'b0, 1'(i % 2), 1'b1, acc);
    idle(ST);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) < 6), 1'b1, acc);
    end
    idle(ST + 2);

    // Reset with work in flight: nothing issued before it may emerge.
    op(64'd11, 64'd22, 1'b0);
    op(64'd33, 64'd44, 1'b1);
    cyc(1'b1, 64'd55, 64'd66, 1'b0, 1'b1, 1'b0, acc);
    #1 chk_reset_state("midreset");
    #1;
    @(negedge clk);
    idle(ST + 2);

    // Fresh op after reset: latency in cycles to out_valid.
    op(64'd100, 64'd58, 1'b1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      idle(1);
      lat++;
    end
    chk("latency", 64'(lat), 64'(ST));
    idle(ST);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
